sram_like_arbiter: RTL and testbench

- Shares one sram-like memory port between the IF-stage fetch master (read-only) and the EXE/MEM data master.
- Sits between the CPU core and the single memory bridge.
- Picks one request per cycle and holds that choice until the slave accepts it.
- Records the source of each accepted transaction in an in-order ID FIFO, then routes each data_ok response back to the right master.

---
 rtl/sram_like_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the fetch master and the data master.
// Define SRAM_ARB_RR_EN for round-robin selection instead of data priority with a streak guard.
module sram_like_arbiter #(
    parameter int OUTSTANDING     = 2,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [31:0] rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] OUT_C    = CW'(OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e                  lock_q, lock_d;
    logic                   grant_q, grant_d;
    logic [OUTSTANDING-1:0] id_q, id_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic sel_data;
    logic owner;
    logic s_req_int;
    logic push;
    logic pop;
    logic head;

`ifdef SRAM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the master that did not win the previous acceptance goes first.
    always_comb begin
        sel_data = data_req & (~inst_req | ~last_q);
    end

    always_comb begin
        last_d = last_q;
        if (push) begin
            last_d = owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int SW = (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX_C = SW'(DATA_STREAK_MAX);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        sel_data = data_req & ~(inst_req & (streak_q == STREAK_MAX_C));
    end

    // Counts data wins that happened while fetch was kept waiting.
    always_comb begin
        streak_d = streak_q;
        if (!inst_req) begin
            streak_d = '0;
        end else if (push && !owner) begin
            streak_d = '0;
        end else if (push && owner && (streak_q != STREAK_MAX_C)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        owner     = (lock_q == LOCKED) ? grant_q : sel_data;
        s_req_int = ~reset & ((lock_q == LOCKED) |
                              ((inst_req | data_req) & (count_q < OUT_C)));
        push      = s_req_int & s_addr_ok;
        pop       = ~reset & s_data_ok & (count_q != '0);
        head      = id_q[rd_ptr_q];
    end

    always_comb begin
        s_req        = s_req_int;
        inst_addr_ok = push & ~owner;
        data_addr_ok = push & owner;
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        rdata        = s_rdata;
        s_wr         = owner ? data_wr    : 1'b0;
        s_size       = owner ? data_size  : 2'd2;
        s_wstrb      = owner ? data_wstrb : 4'd0;
        s_addr       = owner ? data_addr  : inst_addr;
        s_wdata      = owner ? data_wdata : 32'd0;
    end

    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        case (lock_q)
            UNLOCKED: begin
                if (s_req_int && !s_addr_ok) begin
                    lock_d  = LOCKED;
                    grant_d = owner;
                end
            end
            LOCKED: begin
                if (s_addr_ok) begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            id_d[wr_ptr_q] = owner;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q   <= UNLOCKED;
            grant_q  <= 1'b0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int OUT = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    bit q[$];
    bit m_locked, m_lock_owner, m_last;
    int m_streak;
    bit m_iacc, m_dacc;
    logic o_iaok, o_daok, o_idok, o_ddok, o_sreq;

    sram_like_arbiter #(.OUTSTANDING(OUT), .DATA_STREAK_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .rdata(rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit pick_owner();
`ifdef SRAM_ARB_RR_EN
        if (!inst_req) return 1'b1;
        if (!data_req) return 1'b0;
        return !m_last;
`else
        if (inst_req && (!data_req || m_streak == SMAX)) return 1'b0;
        return 1'b1;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        m_locked = 0;
        m_lock_owner = 0;
        m_last = 0;
        m_streak = 0;
        m_iacc = 0;
        m_dacc = 0;
    endtask

    // Called just after a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        bit sreq, own, acc, pop, hd;
        #1;
        if (m_locked) begin
            sreq = 1;
            own  = m_lock_owner;
        end else begin
            sreq = (inst_req || data_req) && (q.size() < OUT);
            own  = pick_owner();
        end
        acc = sreq && s_addr_ok;
        pop = s_data_ok && (q.size() > 0);
        hd  = pop ? q[0] : 1'b0;
        o_iaok = inst_addr_ok; o_daok = data_addr_ok;
        o_idok = inst_data_ok; o_ddok = data_data_ok; o_sreq = s_req;
        chk("s_req", {31'd0, s_req}, {31'd0, sreq});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && !own});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && own});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, pop && !hd});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, pop && hd});
        chk("rdata", rdata, s_rdata);
        if (sreq) begin
            chk("s_addr", s_addr, own ? data_addr : inst_addr);
            chk("s_wdata", s_wdata, own ? data_wdata : 32'd0);
            chk("s_wr", {31'd0, s_wr}, {31'd0, own ? data_wr : 1'b0});
            chk("s_size", {30'd0, s_size}, {30'd0, own ? data_size : 2'd2});
            chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, own ? data_wstrb : 4'd0});
        end
        m_iacc = acc && !own;
        m_dacc = acc && own;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(own);
        m_locked = sreq && !s_addr_ok;
        m_lock_owner = own;
`ifdef SRAM_ARB_RR_EN
        if (acc) m_last = own;
`else
        if (!inst_req) m_streak = 0;
        else if (acc && !own) m_streak = 0;
        else if (acc && own && m_streak < SMAX) m_streak++;
`endif
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        inst_req = 1; s_addr_ok = 1; s_data_ok = 1;
        #1;
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_iaok", {31'd0, inst_addr_ok}, 32'd0);
        chk("rst_idok", {31'd0, inst_data_ok}, 32'd0);
        chk("rst_ddok", {31'd0, data_data_ok}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 0;
        model_clear();
    endtask

    task automatic drive_rand(input int dok_pct);
        if (!inst_req || m_iacc) begin
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!data_req || m_dacc) begin
            data_req   = ($urandom_range(0, 3) != 0);
            data_wr    = $urandom_range(0, 1) == 1;
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom());
            data_addr  = $urandom();
            data_wdata = $urandom();
        end
        s_addr_ok = ($urandom_range(0, 2) != 0);
        s_data_ok = ($urandom_range(0, 99) < dok_pct);
        s_rdata   = $urandom();
    endtask

    initial begin
        logic [9:0] pat;
        reset = 1;
        idle_inputs();
        model_clear();
        @(negedge clk);
        do_reset();

        // fetch-only read
        inst_req = 1; inst_addr = 32'h1c00_0000; s_addr_ok = 1;
        step();
        chk("io_iaok", {31'd0, o_iaok}, 32'd1);
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0280_0c04;
        step();
        chk("io_idok", {31'd0, o_idok}, 32'd1);
        chk("io_ddok", {31'd0, o_ddok}, 32'd0);
        s_data_ok = 0;

        // contention
        do_reset();
        inst_req = 1; data_req = 1; s_addr_ok = 1; s_data_ok = 1;
        pat = 10'b1000010000;
        for (int i = 0; i < 10; i++) begin
            data_addr = 32'h100 + 32'(i);
            step();
`ifndef SRAM_ARB_RR_EN
            chk("cont_inst_grant", {31'd0, o_iaok}, {31'd0, pat[i]});
`endif
            chk("cont_any_grant", {31'd0, o_iaok | o_daok}, 32'd1);
        end

        // lock: data write held off, fetch arrives mid-lock
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
        data_addr = 32'h1000; data_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            s_addr_ok = (i == 3);
            inst_req = (i >= 1);
            step();
            chk("lock_daok", {31'd0, o_daok}, {31'd0, i == 3});
            chk("lock_iaok", {31'd0, o_iaok}, 32'd0);
        end
        data_req = 0;

        // outstanding limit and response ordering
        do_reset();
        inst_req = 1; s_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1;
        step();
        data_req = 0; inst_req = 1; inst_addr = 32'h40;
        step();
        chk("full_sreq", {31'd0, o_sreq}, 32'd0);
        s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000_AAAA;
        step();
        chk("ord_idok", {31'd0, o_idok}, 32'd1);
        chk("full_pop_sreq", {31'd0, o_sreq}, 32'd0);
        s_rdata = 32'h0000_BBBB;
        step();
        chk("ord_ddok", {31'd0, o_ddok}, 32'd1);
        chk("reraise_sreq", {31'd0, o_sreq}, 32'd1);
        s_data_ok = 0; s_addr_ok = 1;
        step();
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1;
        step();

        // spurious response on empty FIFO
        step();
        chk("spur_idok", {31'd0, o_idok}, 32'd0);
        chk("spur_ddok", {31'd0, o_ddok}, 32'd0);
        s_data_ok = 0;

        // async reset with two outstanding
        do_reset();
        inst_req = 1; s_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1;
        step();
        data_req = 0; inst_req = 1; s_addr_ok = 1; s_data_ok = 1;
        #2 reset = 1;
        #1;
        chk("ar_sreq", {31'd0, s_req}, 32'd0);
        chk("ar_iaok", {31'd0, inst_addr_ok}, 32'd0);
        chk("ar_idok", {31'd0, inst_data_ok}, 32'd0);
        chk("ar_ddok", {31'd0, data_data_ok}, 32'd0);
        @(negedge clk);
        reset = 0;
        model_clear();
        idle_inputs();
        s_data_ok = 1;
        step();
        chk("late_idok", {31'd0, o_idok}, 32'd0);
        chk("late_ddok", {31'd0, o_ddok}, 32'd0);
        s_data_ok = 0; inst_req = 1; inst_addr = 32'h1c00_0004; s_addr_ok = 1;
        step();
        chk("post_rst_iaok", {31'd0, o_iaok}, 32'd1);
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1;
        step();
        chk("post_rst_idok", {31'd0, o_idok}, 32'd1);

        // random traffic, alternating slow and fast response phases
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_rand(((i / 200) % 2 == 0) ? 25 : 80);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
